// File: rtl/rca_pkg.sv
// Shared constants for the 4-bit ripple-carry adder.
package rca_pkg;
  localparam int unsigned RCA_WIDTH = 4;
  localparam logic [RCA_WIDTH-1:0] RCA_SUM_RST = 4'h0;
endpackage

// File: rtl/full_adder.sv
// Single-bit full adder stage of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/ripple_carry_adder_4bit.sv
// 4-bit ripple-carry adder with combinational and optional registered results.
// RCA_OUTPUT_REG_EN: when defined, s_q/cout_q/ovf_q are flops; otherwise wires.
module ripple_carry_adder_4bit
  import rca_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [RCA_WIDTH-1:0] a,
  input  logic [RCA_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [RCA_WIDTH-1:0] s,
  output logic                 cout,
  output logic                 ovf,
  output logic [RCA_WIDTH-1:0] s_q,
  output logic                 cout_q,
  output logic                 ovf_q
);
  logic [RCA_WIDTH:0] c;

  assign c[0] = cin;

  // Carry ripples strictly stage to stage; no lookahead.
  for (genvar i = 0; i < RCA_WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[RCA_WIDTH];
  assign ovf  = c[RCA_WIDTH-1] ^ c[RCA_WIDTH];

`ifdef RCA_OUTPUT_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= RCA_SUM_RST;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      s_q    <= s;
      cout_q <= cout;
      ovf_q  <= ovf;
    end
  end
`else
  // Clock and reset are kept on the port list for a uniform interface.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign s_q    = s;
  assign cout_q = cout;
  assign ovf_q  = ovf;
`endif
endmodule

// File: tb/tb_ripple_carry_adder_4bit.sv
// Self-checking bench: arithmetic reference model plus directed literal vectors.
module tb_ripple_carry_adder_4bit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic       cin = 1'b0;
  logic [3:0] s, s_q;
  logic       cout, ovf, cout_q, ovf_q;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  ripple_carry_adder_4bit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .s      (s),
    .cout   (cout),
    .ovf    (ovf),
    .s_q    (s_q),
    .cout_q (cout_q),
    .ovf_q  (ovf_q)
  );

  always #5 clk = ~clk;

  // {ovf, cout, s[3:0]} from plain integer addition and sign rules.
  function automatic logic [5:0] model(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [4:0] sum;
    logic       v;
    sum = {1'b0, x} + {1'b0, y} + {4'b0, ci};
    v   = (x[3] == y[3]) && (sum[3] != x[3]);
    return {v, sum};
  endfunction

  task automatic check(input string nm, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (a=%h b=%h cin=%b)", nm, act, exp, a, b, cin);
    end
  endtask

  logic [5:0] exp_q;
`ifdef RCA_OUTPUT_REG_EN
  always @(posedge clk or negedge rst_n)
    if (!rst_n) exp_q = 6'h00;
    else        exp_q = model(a, b, cin);
`else
  always_comb exp_q = model(a, b, cin);
`endif

  always @(negedge clk)
    if (chk_en) begin
      check("comb", {ovf, cout, s}, model(a, b, cin));
      check("reg", {ovf_q, cout_q, s_q}, exp_q);
    end

  task automatic apply(input logic [3:0] x, input logic [3:0] y, input logic ci);
    @(posedge clk);
    #2;
    a = x; b = y; cin = ci;
    #1;
  endtask

  initial begin
    #1;
    check("reset_q", {ovf_q, cout_q, s_q}, 6'h00);
    check("reset_comb", {ovf, cout, s}, 6'h00);

    check("model_4_8_1", model(4'h4, 4'h8, 1'b1), 6'b00_1101);
    check("model_3_7_0", model(4'h3, 4'h7, 1'b0), 6'b10_1010);
    check("model_f_f_1", model(4'hF, 4'hF, 1'b1), 6'b01_1111);

    @(negedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    apply(4'h4, 4'h8, 1'b0); check("d_4_8_0", {ovf, cout, s}, 6'b00_1100);
    apply(4'h4, 4'h8, 1'b1); check("d_4_8_1", {ovf, cout, s}, 6'b00_1101);
    apply(4'h3, 4'h7, 1'b0); check("d_3_7_0", {ovf, cout, s}, 6'b10_1010);
    apply(4'h3, 4'h7, 1'b1); check("d_3_7_1", {ovf, cout, s}, 6'b10_1011);
    apply(4'hC, 4'h5, 1'b0); check("d_c_5_0", {ovf, cout, s}, 6'b01_0001);
    apply(4'hC, 4'h5, 1'b1); check("d_c_5_1", {ovf, cout, s}, 6'b01_0010);
    apply(4'hF, 4'h0, 1'b1); check("d_f_0_1", {ovf, cout, s}, 6'b01_0000);
    apply(4'hF, 4'hF, 1'b1); check("d_f_f_1", {ovf, cout, s}, 6'b01_1111);
    apply(4'h7, 4'h1, 1'b0); check("d_7_1_0", {ovf, cout, s}, 6'b10_1000);
    apply(4'h8, 4'h8, 1'b0); check("d_8_8_0", {ovf, cout, s}, 6'b11_0000);

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = i[8:0];
      apply(v[3:0], v[7:4], v[8]);
    end

`ifdef RCA_OUTPUT_REG_EN
    apply(4'h3, 4'h7, 1'b0);
    @(posedge clk);
    #2;
    a = 4'hC; b = 4'h5; cin = 1'b1;
    #1;
    check("pre_edge_q", {ovf_q, cout_q, s_q}, 6'b10_1010);
    @(posedge clk);
    #1;
    check("post_edge_q", {ovf_q, cout_q, s_q}, 6'b01_0010);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_q", {ovf_q, cout_q, s_q}, 6'b00_0000);
    check("rst_comb_s", {2'b00, s}, 6'h02);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("recapture_q", {ovf_q, cout_q, s_q}, 6'b01_0010);
`else
    chk_en = 1'b0;
    @(negedge clk);
    a = 4'h3; b = 4'h7; cin = 1'b1;
    #1;
    check("zero_lat_q", {ovf_q, cout_q, s_q}, 6'b10_1011);
    rst_n = 1'b0;
    #1;
    check("rst_noeffect_q", {ovf_q, cout_q, s_q}, 6'b10_1011);
    rst_n = 1'b1;
`endif

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ripple_carry_adder_4bit.md
# ripple_carry_adder_4bit

4-bit binary adder built as a chain of four 1-bit full adders with carry rippling from bit 0 to bit 3. It provides a purely combinational sum/carry path and a clocked copy of the result for downstream synchronous logic. It is a leaf arithmetic block, instantiated wherever a small unsigned or two's-complement add with carry-in is needed.

## Interface
- Parameters: none; the width is fixed at 4 bits by the package constant RCA_WIDTH.
- clk  input  1  rising-edge clock for the registered outputs.
- rst_n  input  1  reset; asynchronous, active-low.
- a  input  4  addend A.
- b  input  4  addend B.
- cin  input  1  carry into bit 0.
- s  output  4  combinational sum, (a + b + cin) mod 16.
- cout  output  1  combinational carry out of bit 3.
- ovf  output  1  combinational signed overflow, equal to carry-into-bit-3 XOR cout.
- s_q  output  4  registered s.
- cout_q  output  1  registered cout.
- ovf_q  output  1  registered ovf.

## Operation
- Build four full_adder stages. Stage i takes a[i], b[i] and c[i], where c[0] = cin. Its sum is a[i]^b[i]^c[i]. Its carry c[i+1] is (a[i]&b[i]) | (c[i]&(a[i]^b[i])).
- cout = c[4].
- ovf = c[3] ^ c[4].
- {cout, s} equals the 5-bit unsigned sum a + b + cin for all 512 input combinations.
- Wrap-around: 4'hF + 4'h0 + 1 gives s = 0 and cout = 1. 4'hF + 4'hF + 1 gives s = 4'hF and cout = 1.
- The carry chain must be a true ripple. Do not use a lookahead or a behavioural "+" for the main path.
- The registered outputs are side outputs only. They never feed back into the combinational path.

## Timing
- s, cout and ovf are combinational with zero clock latency. They follow any change on a, b or cin. The worst-case path is cin → c1 → c2 → c3 → c4.
- s_q, cout_q and ovf_q have 1-cycle latency. They capture s, cout and ovf on each rising edge of clk while rst_n = 1.
- Reset values: s_q = 4'h0, cout_q = 0, ovf_q = 0.
- Asserting rst_n low clears the registered outputs immediately, regardless of clk, including mid-operation.
- Reset has no effect on s, cout or ovf.
- First capture after reset is the first rising clk edge with rst_n = 1.
- If inputs change and a clock edge occurs in the same cycle, the register captures the value settled before the edge.

## Configuration
- RCA_OUTPUT_REG_EN defined: s_q, cout_q and ovf_q are flip-flops as described in Timing.
- RCA_OUTPUT_REG_EN undefined:
  - No flip-flops are instantiated.
  - s_q, cout_q and ovf_q are continuous copies of s, cout and ovf.
  - clk and rst_n remain on the port list but are unused.
  - Port list is identical in both builds.

## Structure
- Shared package rca_pkg holds:
  - RCA_WIDTH = 4.
  - The reset constant RCA_SUM_RST = 4'h0.
- One sub-module, full_adder: ports a, b, cin, s, cout, all 1 bit, purely combinational.
  - The top level instantiates four full_adder stages via a generate loop.
  - The top level also holds the output register, under the macro.

## Test plan
- a=4'h4, b=4'h8, cin=0 → s=4'b1100, cout=0, ovf=0. Then set cin=1 → s=4'b1101, cout=0.
- a=4'h3, b=4'h7, cin=0 → s=4'b1010, cout=0, ovf=1. Then set cin=1 → s=4'b1011, cout=0, ovf=1.
- a=4'hC, b=4'h5, cin=0 → s=4'b0001, cout=1, ovf=0. Then set cin=1 → s=4'b0010, cout=1.
- Exhaustive sweep of a, b and cin (512 vectors) → {cout, s} == a+b+cin and ovf matches the signed-overflow reference on every vector. Also check a=4'hF, b=4'h0, cin=1 → s=0, cout=1.
- With RCA_OUTPUT_REG_EN, apply a=4'hC, b=4'h5, cin=1:
  - Before the clock edge: s_q/cout_q still hold the prior values.
  - After one rising edge: s_q=4'h2 and cout_q=1.
  - Pulse rst_n low between edges: s_q=0, cout_q=0 and ovf_q=0 immediately, while s stays 4'h2.
- Without RCA_OUTPUT_REG_EN, apply a=4'h3, b=4'h7, cin=1 with clk held static → s_q=4'hB, cout_q=0, ovf_q=1 with zero latency.
